priv_1_12_mode_ctrl: RTL and testbench
======================================

Name: priv_1_12_mode_ctrl

Overview:
Parametrised privilege-mode and trap controller for the v1.12 privileged unit. It replaces the fixed M_MODE tie-off with live M/S/U mode tracking, and owns the mstatus stack fields (MIE/SIE/MPIE/SPIE/MPP/SPP). It arbitrates exceptions against NUM_IRQ interrupt lines, applies medeleg/mideleg delegation, and hands one trap at a time to the pipeline through a req/ack handshake. It sits between priv_1_12_csr, which supplies mie/mip/deleg values, and the pipeline redirect logic.

Parameters:
NUM_IRQ, 12, number of interrupt cause lines (12..32); bit i is cause code i
SUPPORT_S, 1, S-mode implemented; 0 forces all delegation off and makes sret illegal
SUPPORT_U, 1, U-mode implemented; 0 maps every U target to M

Ports:
CLK  in  1  clock
RST  in  1  reset, synchronous, active-high
irq_pending  in  NUM_IRQ  mip bits, level
irq_enable  in  NUM_IRQ  mie bits
mideleg  in  NUM_IRQ  interrupt delegation to S
medeleg  in  16  exception delegation to S
exc_valid  in  1  synchronous exception from pipeline, held until trap_ack
exc_cause  in  4  exception code
mret  in  1  mret retiring
sret  in  1  sret retiring
status_we  in  1  mstatus/sstatus write
status_wdata  in  32  write value, mstatus bit layout
trap_ack  in  1  pipeline accepted redirect
curr_priv  out  2  current mode (U=00, S=01, M=11)
status_rdata  out  32  SIE[1] MIE[3] SPIE[5] MPIE[7] SPP[8] MPP[12:11]; other bits 0
trap_valid  out  1  trap request
trap_to_s  out  1  trap is handled in S-mode
trap_cause  out  32  bit31 = interrupt, bits[4:0] = code
ret_illegal  out  1  1-cycle pulse on illegal xRET

Behaviour:
- Reset (RST=1 at a CLK edge): curr_priv=M; MIE=SIE=MPIE=SPIE=0; MPP=M; SPP=0. FSM goes to IDLE. trap_valid=0, trap_to_s=0, trap_cause=0, ret_illegal=0. Reset wins over every other input and aborts a pending trap.
- Interrupt eligibility: line i is active when irq_pending[i] & irq_enable[i]. Its target is S if SUPPORT_S & mideleg[i], otherwise M.
  - M target is taken if curr_priv<M, or curr_priv==M and MIE=1.
  - S target is taken if curr_priv==U, or curr_priv==S and SIE=1. It is never taken while in M.
- Interrupt priority, high to low: 11, 3, 7, 9, 1, 5; then causes 16..NUM_IRQ-1, highest index first. All other indices are ignored.
- Exception target: S if SUPPORT_S & medeleg[exc_cause] & curr_priv!=M, otherwise M.
- Exceptions always take priority over interrupts.
- FSM IDLE:
  - If exc_valid or any eligible interrupt: latch cause and target, go to PEND. trap_valid rises on the next cycle (1-cycle latency).
  - Else if mret or sret: perform the return this cycle (below).
- FSM PEND: trap_valid=1 and cause/target are held stable.
  - A deasserting interrupt does not cancel the request.
  - If exc_valid rises while an interrupt is latched, the exception replaces the latched cause and target in the same cycle (preemption). An exception is never replaced.
  - trap_ack=1: commit, go to IDLE, trap_valid=0 next cycle.
- Commit to M: MPIE<=MIE, MIE<=0, MPP<=curr_priv, curr_priv<=M.
- Commit to S: SPIE<=SIE, SIE<=0, SPP<=curr_priv[0], curr_priv<=S.
- mret (IDLE only):
  - curr_priv<=MPP, MIE<=MPIE, MPIE<=1.
  - MPP<=U, or MPP<=M if SUPPORT_U=0.
  - Illegal when curr_priv!=M: then pulse ret_illegal and leave state unchanged.
- sret:
  - curr_priv<=SPP ? S : U, SIE<=SPIE, SPIE<=1, SPP<=0.
  - Illegal when SUPPORT_S=0 or curr_priv==U.
- Simultaneous events:
  - exc_valid together with xRET: the exception wins and the return is dropped.
  - A trap commit and status_we in the same cycle: the commit wins.
  - status_we and xRET in the same cycle: the xRET wins.
  - mret and sret together: mret wins.
  - xRET seen in PEND: ignored.
- status_we WARL rules:
  - MPP=2'b10 retains the old value. MPP=S when SUPPORT_S=0 retains the old value. MPP=U when SUPPORT_U=0 retains the old value.
  - SIE/SPIE/SPP are hardwired 0 when SUPPORT_S=0.
- status_rdata is combinational from the registered fields.
- The internal trap_cause is registered.

Test Plan:
- Reset then curr_priv=M, MIE=1 (status_wdata=0x8), irq_enable[7]=irq_pending[7]=1 -> trap_valid=1 one cycle later with trap_cause=0x80000007 and trap_to_s=0. After trap_ack: curr_priv=M, MIE=0, MPIE=1, MPP=M, and status_rdata=0x1880.
- In U-mode with lines 3, 7 and 11 all pending and enabled -> trap_cause=0x8000000B. After ack, clear irq 11 and mret -> curr_priv=U, and the next trap_cause=0x80000003.
- curr_priv=U, medeleg[8]=1, exc_valid with exc_cause=8 -> trap_to_s=1 and trap_cause=0x00000008. After ack: curr_priv=S, SPP=0. sret -> curr_priv=U, SIE=SPIE value, SPIE=1.
- In PEND on interrupt 7, assert exc_valid with exc_cause=2 before ack -> trap_cause switches to 0x00000002 the same cycle. trap_ack -> exactly one commit.
- mret issued in U-mode -> ret_illegal pulses for 1 cycle and curr_priv stays U. Separately, status_we with MPP=2'b10 -> MPP is unchanged.
- Assert RST while in PEND -> trap_valid=0, curr_priv=M, status_rdata=0x1800 the next cycle.

Source files
------------

// File: rtl/priv_1_12_mode_ctrl.sv
// Privilege-mode and trap controller: tracks M/S/U mode, owns the mstatus stack
// fields, arbitrates exceptions against interrupts and hands traps to the pipeline.
module priv_1_12_mode_ctrl #(
    parameter int NUM_IRQ   = 12,
    parameter bit SUPPORT_S = 1'b1,
    parameter bit SUPPORT_U = 1'b1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_IRQ-1:0] irq_pending,
    input  logic [NUM_IRQ-1:0] irq_enable,
    input  logic [NUM_IRQ-1:0] mideleg,
    input  logic [15:0]        medeleg,
    input  logic               exc_valid,
    input  logic [3:0]         exc_cause,
    input  logic               mret,
    input  logic               sret,
    input  logic               status_we,
    input  logic [31:0]        status_wdata,
    input  logic               trap_ack,
    output logic [1:0]         curr_priv,
    output logic [31:0]        status_rdata,
    output logic               trap_valid,
    output logic               trap_to_s,
    output logic [31:0]        trap_cause,
    output logic               ret_illegal
);

    typedef enum logic {IDLE, PEND} stateT;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;
    localparam logic [1:0] LOWEST = SUPPORT_U ? PRIV_U : PRIV_M;
    // Fixed-priority causes, listed lowest to highest so later hits override.
    localparam int PRIO [6] = '{5, 1, 9, 7, 3, 11};

    stateT       stateQ, stateD;
    logic [1:0]  privQ, privD, mppQ, mppD;
    logic        mieQ, mieD, sieQ, sieD, mpieQ, mpieD, spieQ, spieD, sppQ, sppD;
    logic [31:0] causeQ, causeD;
    logic        toSQ, toSD, retIllegalQ, retIllegalD;

    logic [NUM_IRQ-1:0] eligible;
    logic        takeM, takeS, irqFound, irqToS, excToS, preempt, effToS;
    logic [4:0]  irqCode;
    logic [31:0] effCause;
    logic        doTrap, doRet, doCommit, mppLegal;
    logic [1:0]  wrMpp;
    logic        unusedWdata;

    assign unusedWdata = ^{status_wdata[31:13], status_wdata[10:9], status_wdata[6],
                           status_wdata[4], status_wdata[2], status_wdata[0]};

    always_comb begin
        takeM    = (privQ != PRIV_M) || mieQ;
        takeS    = SUPPORT_S && ((privQ == PRIV_U) || ((privQ == PRIV_S) && sieQ));
        eligible = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            eligible[i] = irq_pending[i] && irq_enable[i] &&
                          ((SUPPORT_S && mideleg[i]) ? takeS : takeM);
        end
        irqFound = 1'b0;
        irqCode  = '0;
        irqToS   = 1'b0;
        for (int i = 16; i < NUM_IRQ; i++) begin
            if (eligible[i]) begin
                irqFound = 1'b1;
                irqCode  = 5'(i);
                irqToS   = SUPPORT_S && mideleg[i];
            end
        end
        for (int k = 0; k < 6; k++) begin
            if (eligible[PRIO[k]]) begin
                irqFound = 1'b1;
                irqCode  = 5'(PRIO[k]);
                irqToS   = SUPPORT_S && mideleg[PRIO[k]];
            end
        end
    end

    // A latched interrupt is displaced by an exception in the same cycle it appears.
    assign excToS   = SUPPORT_S && medeleg[exc_cause] && (privQ != PRIV_M);
    assign preempt  = (stateQ == PEND) && causeQ[31] && exc_valid;
    assign effToS   = preempt ? excToS : toSQ;
    assign effCause = preempt ? {28'b0, exc_cause} : causeQ;

    assign doTrap   = (stateQ == IDLE) && (exc_valid || irqFound);
    assign doRet    = (stateQ == IDLE) && !doTrap && (mret || sret);
    assign doCommit = (stateQ == PEND) && trap_ack;
    assign wrMpp    = status_wdata[12:11];
    assign mppLegal = (wrMpp != 2'b10) && ((wrMpp != PRIV_S) || SUPPORT_S) &&
                      ((wrMpp != PRIV_U) || SUPPORT_U);

    always_comb begin
        stateD      = stateQ;
        privD       = privQ;
        mppD        = mppQ;
        mieD        = mieQ;
        sieD        = sieQ;
        mpieD       = mpieQ;
        spieD       = spieQ;
        sppD        = sppQ;
        causeD      = causeQ;
        toSD        = toSQ;
        retIllegalD = 1'b0;

        if (status_we && !doRet && !doCommit) begin
            mieD  = status_wdata[3];
            mpieD = status_wdata[7];
            sieD  = SUPPORT_S && status_wdata[1];
            spieD = SUPPORT_S && status_wdata[5];
            sppD  = SUPPORT_S && status_wdata[8];
            if (mppLegal) mppD = wrMpp;
        end

        if (doTrap) begin
            stateD = PEND;
            if (exc_valid) begin
                causeD = {28'b0, exc_cause};
                toSD   = excToS;
            end else begin
                causeD = {1'b1, 26'b0, irqCode};
                toSD   = irqToS;
            end
        end else if (doRet && mret) begin
            if (privQ == PRIV_M) begin
                privD = mppQ;
                mieD  = mpieQ;
                mpieD = 1'b1;
                mppD  = LOWEST;
            end else begin
                retIllegalD = 1'b1;
            end
        end else if (doRet) begin
            if (!SUPPORT_S || (privQ == PRIV_U)) begin
                retIllegalD = 1'b1;
            end else begin
                privD = sppQ ? PRIV_S : LOWEST;
                sieD  = spieQ;
                spieD = 1'b1;
                sppD  = 1'b0;
            end
        end

        if (stateQ == PEND) begin
            causeD = effCause;
            toSD   = effToS;
        end

        if (doCommit) begin
            stateD = IDLE;
            if (effToS) begin
                spieD = sieQ;
                sieD  = 1'b0;
                sppD  = privQ[0];
                privD = PRIV_S;
            end else begin
                mpieD = mieQ;
                mieD  = 1'b0;
                mppD  = privQ;
                privD = PRIV_M;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stateQ      <= IDLE;
            privQ       <= PRIV_M;
            mppQ        <= PRIV_M;
            mieQ        <= 1'b0;
            sieQ        <= 1'b0;
            mpieQ       <= 1'b0;
            spieQ       <= 1'b0;
            sppQ        <= 1'b0;
            causeQ      <= '0;
            toSQ        <= 1'b0;
            retIllegalQ <= 1'b0;
        end else begin
            stateQ      <= stateD;
            privQ       <= privD;
            mppQ        <= mppD;
            mieQ        <= mieD;
            sieQ        <= sieD;
            mpieQ       <= mpieD;
            spieQ       <= spieD;
            sppQ        <= sppD;
            causeQ      <= causeD;
            toSQ        <= toSD;
            retIllegalQ <= retIllegalD;
        end
    end

    assign curr_priv    = privQ;
    assign trap_valid   = (stateQ == PEND);
    assign trap_to_s    = effToS;
    assign trap_cause   = effCause;
    assign ret_illegal  = retIllegalQ;
    assign status_rdata = {19'b0, mppQ, 2'b0, sppQ, mpieQ, 1'b0, spieQ, 1'b0,
                           mieQ, 1'b0, sieQ, 1'b0};

endmodule

// File: tb/tb_priv_1_12_mode_ctrl.sv
// Directed bench for priv_1_12_mode_ctrl: traps, delegation, preemption, xRET and reset.
module tb_priv_1_12_mode_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [11:0] irq_pending, irq_enable, mideleg;
    logic [15:0] medeleg;
    logic        exc_valid, mret, sret, status_we, trap_ack;
    logic [3:0]  exc_cause;
    logic [31:0] status_wdata;
    logic [1:0]  curr_priv;
    logic [31:0] status_rdata, trap_cause;
    logic        trap_valid, trap_to_s, ret_illegal;

    int assertCount = 0;
    int failCount   = 0;

    priv_1_12_mode_ctrl dut (
        .CLK          (CLK),
        .RST          (RST),
        .irq_pending  (irq_pending),
        .irq_enable   (irq_enable),
        .mideleg      (mideleg),
        .medeleg      (medeleg),
        .exc_valid    (exc_valid),
        .exc_cause    (exc_cause),
        .mret         (mret),
        .sret         (sret),
        .status_we    (status_we),
        .status_wdata (status_wdata),
        .trap_ack     (trap_ack),
        .curr_priv    (curr_priv),
        .status_rdata (status_rdata),
        .trap_valid   (trap_valid),
        .trap_to_s    (trap_to_s),
        .trap_cause   (trap_cause),
        .ret_illegal  (ret_illegal)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic writeStatus(input logic [31:0] value);
        status_we    = 1'b1;
        status_wdata = value;
        applyStimulus(1);
        status_we    = 1'b0;
    endtask

    initial begin
        RST = 1'b1; irq_pending = '0; irq_enable = '0; mideleg = '0; medeleg = '0;
        exc_valid = 1'b0; exc_cause = '0; mret = 1'b0; sret = 1'b0;
        status_we = 1'b0; status_wdata = '0; trap_ack = 1'b0;
        applyStimulus(2);
        RST = 1'b0;
        checkOutput("rst_priv", 32'(curr_priv), 32'h3);
        checkOutput("rst_status", status_rdata, 32'h1800);
        checkOutput("rst_valid", 32'(trap_valid), 32'h0);
        checkOutput("rst_cause", trap_cause, 32'h0);
        checkOutput("rst_illegal", 32'(ret_illegal), 32'h0);

        // M-mode interrupt 7 with MIE set
        writeStatus(32'h8);
        checkOutput("mie_write", status_rdata, 32'h0008);
        irq_pending = 12'h080; irq_enable = 12'h080;
        applyStimulus(1);
        checkOutput("t1_valid", 32'(trap_valid), 32'h1);
        checkOutput("t1_cause", trap_cause, 32'h80000007);
        checkOutput("t1_to_s", 32'(trap_to_s), 32'h0);
        trap_ack = 1'b1;
        applyStimulus(1);
        trap_ack = 1'b0; irq_pending = '0; irq_enable = '0;
        checkOutput("t1_valid_off", 32'(trap_valid), 32'h0);
        checkOutput("t1_priv", 32'(curr_priv), 32'h3);
        checkOutput("t1_status", status_rdata, 32'h1880);

        // Drop to U via mret, then priority among 3, 7, 11
        writeStatus(32'h0);
        mret = 1'b1;
        applyStimulus(1);
        mret = 1'b0;
        checkOutput("t2_priv_u", 32'(curr_priv), 32'h0);
        checkOutput("t2_status", status_rdata, 32'h0080);
        irq_pending = 12'h888; irq_enable = 12'h888;
        applyStimulus(1);
        checkOutput("t2_cause11", trap_cause, 32'h8000000B);
        trap_ack = 1'b1;
        applyStimulus(1);
        trap_ack = 1'b0; irq_pending = 12'h088;
        checkOutput("t2_priv_m", 32'(curr_priv), 32'h3);
        checkOutput("t2_status2", status_rdata, 32'h0000);
        mret = 1'b1;
        applyStimulus(1);
        mret = 1'b0;
        checkOutput("t2_mret_priv", 32'(curr_priv), 32'h0);
        applyStimulus(1);
        checkOutput("t2_valid3", 32'(trap_valid), 32'h1);
        checkOutput("t2_cause3", trap_cause, 32'h80000003);
        trap_ack = 1'b1;
        applyStimulus(1);
        trap_ack = 1'b0; irq_pending = '0; irq_enable = '0;
        checkOutput("t2_status3", status_rdata, 32'h0000);

        // Delegated exception 8 from U goes to S, then sret back
        mret = 1'b1;
        applyStimulus(1);
        mret = 1'b0;
        checkOutput("t3_priv_u", 32'(curr_priv), 32'h0);
        medeleg = 16'h0100; exc_valid = 1'b1; exc_cause = 4'd8;
        applyStimulus(1);
        checkOutput("t3_to_s", 32'(trap_to_s), 32'h1);
        checkOutput("t3_cause", trap_cause, 32'h00000008);
        trap_ack = 1'b1;
        applyStimulus(1);
        trap_ack = 1'b0; exc_valid = 1'b0;
        checkOutput("t3_priv_s", 32'(curr_priv), 32'h1);
        checkOutput("t3_status", status_rdata, 32'h0080);
        sret = 1'b1;
        applyStimulus(1);
        sret = 1'b0;
        checkOutput("t3_sret_priv", 32'(curr_priv), 32'h0);
        checkOutput("t3_sret_status", status_rdata, 32'h00A0);

        // Illegal mret from U
        mret = 1'b1;
        applyStimulus(1);
        mret = 1'b0;
        checkOutput("t5_illegal", 32'(ret_illegal), 32'h1);
        checkOutput("t5_priv", 32'(curr_priv), 32'h0);
        applyStimulus(1);
        checkOutput("t5_illegal_off", 32'(ret_illegal), 32'h0);
        checkOutput("t5_status", status_rdata, 32'h00A0);

        // Exception preempts a latched interrupt
        irq_pending = 12'h080; irq_enable = 12'h080;
        applyStimulus(1);
        checkOutput("t4_irq_cause", trap_cause, 32'h80000007);
        exc_valid = 1'b1; exc_cause = 4'd2;
        #1;
        checkOutput("t4_preempt", trap_cause, 32'h00000002);
        checkOutput("t4_pre_to_s", 32'(trap_to_s), 32'h0);
        applyStimulus(1);
        checkOutput("t4_held", trap_cause, 32'h00000002);
        trap_ack = 1'b1;
        applyStimulus(1);
        trap_ack = 1'b0; exc_valid = 1'b0; irq_pending = '0; irq_enable = '0;
        checkOutput("t4_valid_off", 32'(trap_valid), 32'h0);
        checkOutput("t4_priv", 32'(curr_priv), 32'h3);
        applyStimulus(1);
        checkOutput("t4_one_commit", status_rdata, 32'h0020);
        checkOutput("t4_idle", 32'(trap_valid), 32'h0);

        // WARL on MPP
        writeStatus(32'h1008);
        checkOutput("warl_keep_u", status_rdata, 32'h0008);
        writeStatus(32'h1808);
        checkOutput("warl_set_m", status_rdata, 32'h1808);
        writeStatus(32'h1008);
        checkOutput("warl_keep_m", status_rdata, 32'h1808);

        // Reset while a trap is pending
        irq_pending = 12'h080; irq_enable = 12'h080;
        applyStimulus(1);
        checkOutput("t6_pend", 32'(trap_valid), 32'h1);
        RST = 1'b1;
        applyStimulus(1);
        RST = 1'b0; irq_pending = '0; irq_enable = '0;
        checkOutput("t6_valid", 32'(trap_valid), 32'h0);
        checkOutput("t6_priv", 32'(curr_priv), 32'h3);
        checkOutput("t6_status", status_rdata, 32'h1800);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
